// File: rtl/bus_master_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the system_bus master port.
// The arbiter takes the master view; the requesters and the bus take the slave view.
interface bus_master_arbiter_if;
  logic [31:0] r0_addr;
  logic [31:0] r0_wdata;
  logic [2:0]  r0_size;
  logic        r0_read;
  logic        r0_write;
  logic [31:0] r0_rdata;
  logic        r0_busy;
  logic        r0_error;

  logic [31:0] r1_addr;
  logic [31:0] r1_wdata;
  logic [2:0]  r1_size;
  logic        r1_read;
  logic        r1_write;
  logic [31:0] r1_rdata;
  logic        r1_busy;
  logic        r1_error;

  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [2:0]  m_size;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_rdata;
  logic        m_busy;
  logic        m_error;

  modport master (
    input  r0_addr, r0_wdata, r0_size, r0_read, r0_write,
    output r0_rdata, r0_busy, r0_error,
    input  r1_addr, r1_wdata, r1_size, r1_read, r1_write,
    output r1_rdata, r1_busy, r1_error,
    output m_addr, m_wdata, m_size, m_read, m_write,
    input  m_rdata, m_busy, m_error
  );

  modport slave (
    output r0_addr, r0_wdata, r0_size, r0_read, r0_write,
    input  r0_rdata, r0_busy, r0_error,
    output r1_addr, r1_wdata, r1_size, r1_read, r1_write,
    input  r1_rdata, r1_busy, r1_error,
    input  m_addr, m_wdata, m_size, m_read, m_write,
    output m_rdata, m_busy, m_error
  );
endinterface

// File: rtl/bus_master_arbiter.sv
// Round-robin arbiter for the CPU (requester 0) and DMA (requester 1) in front of system_bus,
// with a command latch at grant and a watchdog that aborts transfers the bus never completes.
module bus_master_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  bus_master_arbiter_if.master bus,
  output logic                grant,
  output logic [TO_CNT_W-1:0] timeout_count
);

  localparam int ACC_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_grant;
  logic [ACC_W-1:0]    r_acc_cnt;
  logic [TO_CNT_W-1:0] r_to_cnt;

  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic [2:0]          r_size;
  logic                r_read;
  logic                r_write;
  logic [31:0]         r_rdata;
  logic                r_error;

  logic                w_req0;
  logic                w_req1;
  logic                w_gnt_req;
  logic                w_sel;
  logic                w_grant_ev;
  logic                w_cmpl;
  logic                w_tout;
  logic                w_done0;
  logic                w_done1;
  logic                w_access;

  function automatic logic [TO_CNT_W-1:0] sat_inc(input logic [TO_CNT_W-1:0] v);
    return (&v) ? v : v + TO_CNT_W'(1);
  endfunction

  always_comb begin
    w_req0     = bus.r0_read | bus.r0_write;
    w_req1     = bus.r1_read | bus.r1_write;
    w_gnt_req  = r_grant ? w_req1 : w_req0;
    // The first ACCESS cycle never completes, so a zero-wait slave still sees one full bus cycle.
    w_cmpl     = (r_state == ACCESS) & ~bus.m_busy & (r_acc_cnt != '0);
    w_tout     = (r_state == ACCESS) & bus.m_busy &
                 (r_acc_cnt == ACC_W'(TIMEOUT_CYCLES - 1));
    w_sel      = r_grant;
    w_next     = r_state;
    case (r_state)
      IDLE: begin
        if (w_req0 & w_req1) begin
          w_sel  = ~r_grant;
          w_next = ACCESS;
        end else if (w_req0) begin
          w_sel  = 1'b0;
          w_next = ACCESS;
        end else if (w_req1) begin
          w_sel  = 1'b1;
          w_next = ACCESS;
        end
      end
      ACCESS: if (w_cmpl | w_tout) w_next = DONE;
      DONE:   if (!w_gnt_req) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    w_grant_ev = (r_state == IDLE) & (w_next == ACCESS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_grant   <= 1'b1;
      r_acc_cnt <= '0;
      r_to_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant_ev) begin
        r_grant   <= w_sel;
        r_acc_cnt <= '0;
      end else if (r_state == ACCESS) begin
        r_acc_cnt <= r_acc_cnt + ACC_W'(1);
      end
      if (w_tout) r_to_cnt <= sat_inc(r_to_cnt);
    end
  end

  // Command and response holding registers carry no reset; outputs are gated by state.
  always_ff @(posedge clk) begin
    if (w_grant_ev) begin
      r_addr  <= w_sel ? bus.r1_addr  : bus.r0_addr;
      r_wdata <= w_sel ? bus.r1_wdata : bus.r0_wdata;
      r_size  <= w_sel ? bus.r1_size  : bus.r0_size;
      r_read  <= w_sel ? bus.r1_read  : bus.r0_read;
      r_write <= w_sel ? bus.r1_write : bus.r0_write;
    end
    if (w_cmpl) begin
      r_rdata <= bus.m_rdata;
      r_error <= bus.m_error;
    end else if (w_tout) begin
      r_rdata <= '0;
      r_error <= 1'b1;
    end
  end

  assign w_access     = (r_state == ACCESS);
  assign w_done0      = (r_state == DONE) & ~r_grant;
  assign w_done1      = (r_state == DONE) &  r_grant;

  assign bus.m_addr   = w_access ? r_addr  : '0;
  assign bus.m_wdata  = w_access ? r_wdata : '0;
  assign bus.m_size   = w_access ? r_size  : '0;
  assign bus.m_read   = w_access & r_read;
  assign bus.m_write  = w_access & r_write & ~r_read;

  assign bus.r0_busy  = w_req0 & ~w_done0;
  assign bus.r1_busy  = w_req1 & ~w_done1;
  assign bus.r0_rdata = w_done0 ? r_rdata : '0;
  assign bus.r1_rdata = w_done1 ? r_rdata : '0;
  assign bus.r0_error = w_done0 & r_error;
  assign bus.r1_error = w_done1 & r_error;

  assign grant         = r_grant;
  assign timeout_count = r_to_cnt;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Bench for bus_master_arbiter: vector table, round-robin and reset sequences, random transfers.
module tb_bus_master_arbiter;
  localparam int T  = 16;
  localparam int CW = 16;

  logic          clk;
  logic          rst_n;
  logic          grant;
  logic [CW-1:0] timeout_count;

  bus_master_arbiter_if bif();

  bus_master_arbiter #(.TIMEOUT_CYCLES(T), .TO_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif), .grant(grant), .timeout_count(timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: stays busy for slv_lat cycles of an active command, then answers.
  int          slv_lat;
  logic [31:0] slv_rdata;
  logic        slv_err;
  int          lat_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lat_cnt <= 0;
    else if (bif.m_read | bif.m_write) lat_cnt <= lat_cnt + 1;
    else lat_cnt <= 0;
  end
  assign bif.m_busy  = (bif.m_read | bif.m_write) && (lat_cnt < slv_lat);
  assign bif.m_rdata = slv_rdata;
  assign bif.m_error = slv_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          n;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  sz;
    int          lat;
    logic [31:0] srd;
    logic        serr;
    logic [31:0] e_rdata;
    logic        e_err;
    int          e_edges;
    int          e_tcnt;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int n, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] s);
    if (n == 0) begin
      bif.r0_addr = a; bif.r0_wdata = d; bif.r0_size = s; bif.r0_read = rd; bif.r0_write = wr;
    end else begin
      bif.r1_addr = a; bif.r1_wdata = d; bif.r1_size = s; bif.r1_read = rd; bif.r1_write = wr;
    end
  endtask

  task automatic clr_req(input int n);
    if (n == 0) begin bif.r0_read = 1'b0; bif.r0_write = 1'b0; end
    else begin bif.r1_read = 1'b0; bif.r1_write = 1'b0; end
  endtask

  function automatic logic busy_of(input int n);
    return (n == 0) ? bif.r0_busy : bif.r1_busy;
  endfunction

  // Waits (bounded) until requester n sees busy low; checks the bus command while it is granted.
  task automatic wait_done(input int n, input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] s, input bit solo,
                           output int edges, output int acc, output bit cmd_ok, output bit oth_ok);
    edges = 0; acc = 0; cmd_ok = 1'b1; oth_ok = 1'b1;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if ((bif.m_read | bif.m_write) && (int'(grant) == n)) begin
        acc++;
        if (bif.m_addr !== a || bif.m_wdata !== d || bif.m_size !== s ||
            bif.m_read !== rd || bif.m_write !== (wr & ~rd)) cmd_ok = 1'b0;
        if (n == 0) bif.r0_wdata = ~d; else bif.r1_wdata = ~d;
      end
      if (solo && busy_of(1 - n)) oth_ok = 1'b0;
    end while (busy_of(n) && edges < 100);
    if (busy_of(n)) chk("busy_wait_bound", 64'(edges), 64'd0);
  endtask

  task automatic finish_xfer(input int n);
    @(posedge clk);
    #1 clr_req(n);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_one(input string tag, input int n, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d, input logic [2:0] s,
                         input int lat, input logic [31:0] srd, input logic serr,
                         input logic [31:0] e_rdata, input logic e_err, input int e_edges,
                         input int e_tcnt);
    int edges, acc;
    bit cmd_ok, oth_ok;
    slv_lat = lat; slv_rdata = srd; slv_err = serr;
    set_req(n, rd, wr, a, d, s);
    wait_done(n, rd, wr, a, d, s, 1'b1, edges, acc, cmd_ok, oth_ok);
    chk({tag, "_rdata"}, (n == 0) ? bif.r0_rdata : bif.r1_rdata, e_rdata);
    chk({tag, "_error"}, (n == 0) ? bif.r0_error : bif.r1_error, e_err);
    chk({tag, "_edges"}, 64'(edges), 64'(e_edges));
    chk({tag, "_grant"}, grant, 64'(n));
    chk({tag, "_tcount"}, timeout_count, 64'(e_tcnt));
    chk({tag, "_cmd"}, cmd_ok, 1);
    chk({tag, "_acc_cycles"}, 64'(acc), 64'(e_edges - 1));
    chk({tag, "_other_busy_ok"}, oth_ok, 1);
    finish_xfer(n);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int          edges, acc, tcnt_exp, n, lat;
    bit          cmd_ok, oth_ok, rd, wr, tout;
    logic [31:0] a, d, srd, e_rdata;
    logic [2:0]  s;
    logic        serr, e_err;

    vt[0] = '{0, 1'b1, 1'b0, 32'h4000_0000, 32'h0, 3'd2, 1, 32'hDEAD_BEEF, 1'b0,
              32'hDEAD_BEEF, 1'b0, 3, 0};
    vt[1] = '{1, 1'b0, 1'b1, 32'h1000_1000, 32'h55AA_55AA, 3'd2, 2, 32'h1234_5678, 1'b0,
              32'h1234_5678, 1'b0, 4, 0};
    vt[2] = '{0, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 3'd2, 0, 32'h0, 1'b1,
              32'h0, 1'b1, 3, 0};
    vt[3] = '{0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 3'd2, 1000, 32'hCAFE_F00D, 1'b0,
              32'h0, 1'b1, 17, 1};
    vt[4] = '{0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 3'd1, 3, 32'hA5A5_A5A5, 1'b0,
              32'hA5A5_A5A5, 1'b0, 5, 1};
    vt[5] = '{1, 1'b1, 1'b1, 32'h0000_0020, 32'h1111_2222, 3'd0, 5, 32'h0BAD_F00D, 1'b0,
              32'h0BAD_F00D, 1'b0, 7, 1};
    vt[6] = '{1, 1'b0, 1'b1, 32'h2000_0000, 32'h7777_8888, 3'd2, 1000, 32'h1, 1'b0,
              32'h0, 1'b1, 17, 2};
    vt[7] = '{0, 1'b0, 1'b1, 32'h3000_0004, 32'h0F0F_0F0F, 3'd2, 0, 32'h9999_0000, 1'b0,
              32'h9999_0000, 1'b0, 3, 2};

    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    slv_lat = 0; slv_rdata = '0; slv_err = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", grant, 1);
    chk("rst_tcount", timeout_count, 0);
    chk("rst_m_outs", |{bif.m_addr, bif.m_wdata, bif.m_size, bif.m_read, bif.m_write}, 0);
    chk("rst_r_outs", |{bif.r0_rdata, bif.r0_busy, bif.r0_error,
                        bif.r1_rdata, bif.r1_busy, bif.r1_error}, 0);
    rst_n = 1'b1;

    // Simultaneous requests straight out of reset: R0, then R1, then R0 again.
    slv_lat = 1; slv_rdata = 32'h0101_0101; slv_err = 1'b0;
    for (int round = 0; round < 2; round++) begin
      set_req(0, 1'b1, 1'b0, 32'h0000_1000, '0, 3'd2);
      set_req(1, 1'b1, 1'b0, 32'h0000_2000, '0, 3'd2);
      wait_done(0, 1'b1, 1'b0, 32'h0000_1000, '0, 3'd2, 1'b0, edges, acc, cmd_ok, oth_ok);
      chk("rr_first_grant", grant, 0);
      chk("rr_loser_stalled", bif.r1_busy, 1);
      chk("rr_first_edges", 64'(edges), 3);
      chk("rr_first_cmd", cmd_ok, 1);
      finish_xfer(0);
      wait_done(1, 1'b1, 1'b0, 32'h0000_2000, '0, 3'd2, 1'b0, edges, acc, cmd_ok, oth_ok);
      chk("rr_second_grant", grant, 1);
      chk("rr_second_rdata", bif.r1_rdata, 32'h0101_0101);
      chk("rr_second_edges", 64'(edges), 3);
      finish_xfer(1);
    end

    for (int i = 0; i < 8; i++)
      run_one($sformatf("vec%0d", i), vt[i].n, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata,
              vt[i].sz, vt[i].lat, vt[i].srd, vt[i].serr, vt[i].e_rdata, vt[i].e_err,
              vt[i].e_edges, vt[i].e_tcnt);

    // Reset pulsed in the middle of a hung transfer.
    slv_lat = 1000;
    set_req(0, 1'b1, 1'b0, 32'h5000_0000, '0, 3'd2);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_m_read", bif.m_read, 0);
    chk("midrst_m_addr", bif.m_addr, 0);
    chk("midrst_grant", grant, 1);
    chk("midrst_tcount", timeout_count, 0);
    chk("midrst_r0_out", |{bif.r0_rdata, bif.r0_error}, 0);
    clr_req(0);
    @(negedge clk);
    rst_n = 1'b1;
    run_one("post_rst", 0, 1'b1, 1'b0, 32'h6000_0000, '0, 3'd2, 1, 32'h600D_600D, 1'b0,
            32'h600D_600D, 1'b0, 3, 0);

    // Random transfers against an outcome model: a slave slower than the watchdog window aborts.
    tcnt_exp = 0;
    for (int i = 0; i < 40; i++) begin
      n    = int'($urandom_range(0, 1));
      rd   = bit'($urandom_range(0, 1));
      wr   = rd ? bit'($urandom_range(0, 1)) : 1'b1;
      lat  = ($urandom_range(0, 7) == 0) ? T + int'($urandom_range(0, 10)) : int'($urandom_range(0, 6));
      a    = $urandom;
      d    = $urandom;
      s    = 3'($urandom_range(0, 7));
      srd  = $urandom;
      serr = 1'($urandom_range(0, 1));
      tout = (lat >= T);
      e_rdata = tout ? 32'h0 : srd;
      e_err   = tout ? 1'b1 : serr;
      edges   = 1 + (tout ? T : ((lat < 1) ? 1 : lat) + 1);
      if (tout && tcnt_exp < (1 << CW) - 1) tcnt_exp++;
      run_one($sformatf("rnd%0d", i), n, rd, wr, a, d, s, lat, srd, serr,
              e_rdata, e_err, edges, tcnt_exp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
